// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU/branch resolution feeding the EX/MEM register.
// Define EX_DIV_EN to build the iterative restoring divider; otherwise DIV decodes as a NOP.
module ex_stage_mc #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ID_EX_ALUOp,
    input  logic [DATA_W-1:0] ID_EX_ReadData1,
    input  logic [DATA_W-1:0] ID_EX_ReadData2,
    input  logic [DATA_W-1:0] ID_EX_SignExtImm,
    input  logic              ID_EX_ALUSrc,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemtoReg,
    input  logic              ID_EX_MemWrite,
    input  logic              ID_EX_MemRead,
    input  logic              ID_EX_Branch,
    input  logic [REG_AW-1:0] ID_EX_Rd,
    input  logic [PC_W-1:0]   ID_EX_PC,
    input  logic              ex_flush,
    output logic [DATA_W-1:0] EX_MEM_ALUResult,
    output logic [DATA_W-1:0] EX_MEM_WriteData,
    output logic [REG_AW-1:0] EX_MEM_WriteReg,
    output logic              EX_MEM_RegWrite,
    output logic              EX_MEM_MemtoRegOut,
    output logic              EX_MEM_MemWriteOut,
    output logic              EX_MEM_MemReadOut,
    output logic              EX_MEM_Branch,
    output logic [PC_W-1:0]   EX_MEM_BranchTarget,
    output logic [2:0]        EX_MEM_Flags,
    output logic              ex_stall
);

    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam logic [4:0] OP_CMP  = 5'd14;

    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] aluResult;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pcPlusOne;
    logic              taken;
    logic              divBubble;
    logic [2:0]        cmpFlags;

    assign opB       = ID_EX_ALUSrc ? ID_EX_SignExtImm : ID_EX_ReadData2;
    assign pcPlusOne = ID_EX_PC + PC_W'(1);
    assign cmpFlags  = {ID_EX_ReadData1 > ID_EX_ReadData2,
                        ID_EX_ReadData1 < ID_EX_ReadData2,
                        ID_EX_ReadData1 == ID_EX_ReadData2};

`ifdef EX_DIV_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  divCount;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W:0]   remShift;
    logic [DATA_W:0]   diff;
    logic              divStart;

    assign divStart  = (state == IDLE) && (ID_EX_ALUOp == OP_DIV) && (opB != '0);
    assign divBubble = divStart || (state == BUSY);
    assign ex_stall  = !rst && !ex_flush && divBubble;
    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    assign remShift  = {rem, quot[DATA_W-1]};
    assign diff      = remShift - {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (rst || ex_flush) begin
            state    <= IDLE;
            divCount <= '0;
        end else begin
            case (state)
                IDLE: if (divStart) begin
                    state    <= BUSY;
                    quot     <= ID_EX_ReadData1;
                    rem      <= '0;
                    divisor  <= opB;
                    divCount <= '0;
                end
                BUSY: begin
                    quot     <= {quot[DATA_W-2:0], !diff[DATA_W]};
                    rem      <= diff[DATA_W] ? remShift[DATA_W-1:0] : diff[DATA_W-1:0];
                    divCount <= divCount + CNT_W'(1);
                    if (divCount == CNT_W'(DATA_W - 1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign divBubble = 1'b0;
    assign ex_stall  = 1'b0;
`endif

    always_comb begin
        aluResult = '0;
        taken     = 1'b0;
        target    = '0;
        case (ID_EX_ALUOp)
            5'd0:        aluResult = ID_EX_ReadData1 + ID_EX_SignExtImm;
            5'd1, 5'd4,
            5'd5, 5'd14: aluResult = ID_EX_ReadData1;
            5'd2, 5'd3:  aluResult = ID_EX_SignExtImm;
            5'd6:        aluResult = ID_EX_ReadData1 + opB;
            5'd7:        aluResult = ID_EX_ReadData1 - opB;
            5'd8:        aluResult = ID_EX_ReadData1 * opB;
            OP_DIV: begin
`ifdef EX_DIV_EN
                aluResult = (opB == '0) ? '1 : quot;
`endif
            end
            5'd10:       aluResult = ID_EX_ReadData1 & opB;
            5'd11:       aluResult = ID_EX_ReadData1 | opB;
            5'd12:       aluResult = ID_EX_ReadData1 << opB[4:0];
            5'd13:       aluResult = ID_EX_ReadData1 >> opB[4:0];
            5'd15:       aluResult = ~ID_EX_ReadData1;
            5'd16: begin taken = 1'b1; target = ID_EX_ReadData1[PC_W-1:0]; end
            5'd17: begin taken = 1'b1; target = ID_EX_PC + ID_EX_SignExtImm[PC_W-1:0]; end
            5'd18: begin
                taken  = |(EX_MEM_Flags & ID_EX_ReadData2[2:0]);
                target = ID_EX_ReadData1[PC_W-1:0];
            end
            5'd19: begin
                taken     = 1'b1;
                target    = ID_EX_ReadData1[PC_W-1:0];
                aluResult = DATA_W'(pcPlusOne);
            end
            5'd20: begin taken = 1'b1; target = ID_EX_ReadData2[PC_W-1:0]; end
            default: ;
        endcase
    end

    // Flush and divider bubbles only squash the controls; data fields are don't-care then.
    always_ff @(posedge clk) begin
        if (rst) begin
            EX_MEM_ALUResult    <= '0;
            EX_MEM_WriteData    <= '0;
            EX_MEM_WriteReg     <= '0;
            EX_MEM_RegWrite     <= 1'b0;
            EX_MEM_MemtoRegOut  <= 1'b0;
            EX_MEM_MemWriteOut  <= 1'b0;
            EX_MEM_MemReadOut   <= 1'b0;
            EX_MEM_Branch       <= 1'b0;
            EX_MEM_BranchTarget <= '0;
            EX_MEM_Flags        <= '0;
        end else if (ex_flush || divBubble) begin
            EX_MEM_RegWrite     <= 1'b0;
            EX_MEM_MemtoRegOut  <= 1'b0;
            EX_MEM_MemWriteOut  <= 1'b0;
            EX_MEM_MemReadOut   <= 1'b0;
            EX_MEM_Branch       <= 1'b0;
        end else begin
            EX_MEM_ALUResult    <= aluResult;
            EX_MEM_WriteData    <= ID_EX_ReadData2;
            EX_MEM_WriteReg     <= ID_EX_Rd;
            EX_MEM_RegWrite     <= ID_EX_RegWrite;
            EX_MEM_MemtoRegOut  <= ID_EX_MemtoReg;
            EX_MEM_MemWriteOut  <= ID_EX_MemWrite;
            EX_MEM_MemReadOut   <= ID_EX_MemRead;
            EX_MEM_Branch       <= ID_EX_Branch & taken;
            EX_MEM_BranchTarget <= target;
            if (ID_EX_ALUOp == OP_CMP) EX_MEM_Flags <= cmpFlags;
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: directed cases plus randomized ops against a reference model.
// Divider checks follow the EX_DIV_EN build option of the design.
module tb_ex_stage_mc;
    localparam int DATA_W = 32;
    localparam int PC_W   = 8;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        ID_EX_ALUOp;
    logic [DATA_W-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
    logic              ID_EX_ALUSrc, ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemWrite;
    logic              ID_EX_MemRead, ID_EX_Branch;
    logic [REG_AW-1:0] ID_EX_Rd;
    logic [PC_W-1:0]   ID_EX_PC;
    logic              ex_flush;
    logic [DATA_W-1:0] EX_MEM_ALUResult, EX_MEM_WriteData;
    logic [REG_AW-1:0] EX_MEM_WriteReg;
    logic              EX_MEM_RegWrite, EX_MEM_MemtoRegOut, EX_MEM_MemWriteOut;
    logic              EX_MEM_MemReadOut, EX_MEM_Branch;
    logic [PC_W-1:0]   EX_MEM_BranchTarget;
    logic [2:0]        EX_MEM_Flags;
    logic              ex_stall;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] modelFlags;

    ex_stage_mc #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_ReadData1(ID_EX_ReadData1),
        .ID_EX_ReadData2(ID_EX_ReadData2),
        .ID_EX_SignExtImm(ID_EX_SignExtImm),
        .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemtoReg(ID_EX_MemtoReg),
        .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_Branch(ID_EX_Branch),
        .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_PC(ID_EX_PC),
        .ex_flush(ex_flush),
        .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_WriteReg(EX_MEM_WriteReg),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemtoRegOut(EX_MEM_MemtoRegOut),
        .EX_MEM_MemWriteOut(EX_MEM_MemWriteOut),
        .EX_MEM_MemReadOut(EX_MEM_MemReadOut),
        .EX_MEM_Branch(EX_MEM_Branch),
        .EX_MEM_BranchTarget(EX_MEM_BranchTarget),
        .EX_MEM_Flags(EX_MEM_Flags),
        .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // ctrl = {RegWrite, MemtoReg, MemWrite, MemRead, Branch}
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic aluSrc, input logic [4:0] ctrl,
                                 input logic [7:0] pc);
        ID_EX_ALUOp      = op;
        ID_EX_ReadData1  = a;
        ID_EX_ReadData2  = b;
        ID_EX_SignExtImm = imm;
        ID_EX_ALUSrc     = aluSrc;
        {ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemWrite, ID_EX_MemRead, ID_EX_Branch} = ctrl;
        ID_EX_Rd         = 5'($urandom);
        ID_EX_PC         = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyNop();
        applyStimulus(5'd21, 32'd0, 32'd0, 32'd0, 1'b0, 5'b00000, 8'd0);
    endtask

    task automatic waitStallLow(output int cycles, output logic bubbleBad);
        cycles = 0;
        bubbleBad = 1'b0;
        while (ex_stall === 1'b1 && cycles < 200) begin
            cycles++;
            tick();
            if (EX_MEM_RegWrite || EX_MEM_MemWriteOut || EX_MEM_MemReadOut || EX_MEM_Branch)
                bubbleBad = 1'b1;
        end
    endtask

    // Reference result; defined is cleared for opcodes whose result the design leaves open.
    function automatic logic [31:0] refResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] imm, input logic aluSrc, input logic [7:0] pc,
                                              output logic defined);
        logic [31:0] bSel = aluSrc ? imm : b;
        logic [63:0] prod = {32'd0, a} * {32'd0, bSel};
        int unsigned nextPc = (int'(pc) + 1) % 256;
        defined = 1'b1;
        case (op)
            5'd0:                    return a + imm;
            5'd1, 5'd4, 5'd5:        return a;
            5'd2, 5'd3:              return imm;
            5'd6:                    return a + bSel;
            5'd7:                    return a - bSel;
            5'd8:                    return prod[31:0];
            5'd10:                   return a & bSel;
            5'd11:                   return a | bSel;
            5'd12:                   return a << (bSel % 32);
            5'd13:                   return a >> (bSel % 32);
            5'd15:                   return ~a;
            5'd19:                   return nextPc;
            default: begin defined = 1'b0; return 32'd0; end
        endcase
    endfunction

    initial begin
        int cycles;
        logic bubbleBad;
        logic [4:0] op, ctrl;
        logic [31:0] a, b, imm, expRes;
        logic [7:0] pc, expTarget;
        logic aluSrc, flush, resDefined, isBranchOp, expTaken;
        logic [4:0] expRd;

        rst = 1'b1;
        ex_flush = 1'b0;
        applyNop();
        tick();
        tick();
        checkOutput("resetResult", EX_MEM_ALUResult, 32'd0);
        checkOutput("resetCtrl", {EX_MEM_RegWrite, EX_MEM_MemtoRegOut, EX_MEM_MemWriteOut,
                                  EX_MEM_MemReadOut, EX_MEM_Branch}, 32'd0);
        checkOutput("resetFlags", EX_MEM_Flags, 32'd0);
        checkOutput("resetStall", ex_stall, 32'd0);
        rst = 1'b0;

        applyStimulus(5'd6, 32'd10, 32'd5, 32'd99, 1'b0, 5'b10000, 8'd0);
        tick();
        checkOutput("addResult", EX_MEM_ALUResult, 32'd15);
        checkOutput("addRegWrite", EX_MEM_RegWrite, 32'd1);

        applyStimulus(5'd0, 32'd28, 32'd7, 32'd15, 1'b1, 5'b01010, 8'd0);
        tick();
        checkOutput("lwAddr", EX_MEM_ALUResult, 32'd43);
        checkOutput("lwMemRead", EX_MEM_MemReadOut, 32'd1);

        applyStimulus(5'd14, 32'd15, 32'd15, 32'd0, 1'b0, 5'b00000, 8'd0);
        tick();
        checkOutput("cmpEqFlags", EX_MEM_Flags, 32'b001);
        applyStimulus(5'd18, 32'd20, 32'b001, 32'd0, 1'b0, 5'b00001, 8'd0);
        tick();
        checkOutput("brflTaken", EX_MEM_Branch, 32'd1);
        checkOutput("brflTarget", EX_MEM_BranchTarget, 32'd20);
        applyStimulus(5'd18, 32'd20, 32'b100, 32'd0, 1'b0, 5'b00001, 8'd0);
        tick();
        checkOutput("brflNotTaken", EX_MEM_Branch, 32'd0);
        checkOutput("brflFlagsHeld", EX_MEM_Flags, 32'b001);

        applyStimulus(5'd17, 32'd0, 32'd0, 32'd10, 1'b0, 5'b00001, 8'd250);
        tick();
        checkOutput("jpcWrapTarget", EX_MEM_BranchTarget, 32'd4);
        checkOutput("jpcBranch", EX_MEM_Branch, 32'd1);

`ifdef EX_DIV_EN
        applyStimulus(5'd9, 32'd100, 32'd7, 32'd0, 1'b0, 5'b10000, 8'd0);
        #1;
        checkOutput("divStallRise", ex_stall, 32'd1);
        waitStallLow(cycles, bubbleBad);
        checkOutput("divStallCycles", cycles, DATA_W + 1);
        checkOutput("divBubbles", bubbleBad, 32'd0);
        tick();
        checkOutput("divQuotient", EX_MEM_ALUResult, 32'd100 / 32'd7);
        checkOutput("divRegWrite", EX_MEM_RegWrite, 32'd1);

        applyStimulus(5'd9, 32'd5, 32'd0, 32'd0, 1'b0, 5'b10000, 8'd0);
        #1;
        checkOutput("div0NoStall", ex_stall, 32'd0);
        tick();
        checkOutput("div0Result", EX_MEM_ALUResult, 32'hFFFF_FFFF);

        // Flush and reset part-way through a division, then a normal ADD.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(5'd9, 32'd1000, 32'd3, 32'd0, 1'b0, 5'b10000, 8'd0);
            repeat (5) tick();
            if (k == 0) ex_flush = 1'b1; else rst = 1'b1;
            #1;
            checkOutput(k == 0 ? "flushStallDrop" : "rstStallDrop", ex_stall, 32'd0);
            tick();
            ex_flush = 1'b0;
            rst = 1'b0;
            applyNop();
            #1;
            checkOutput(k == 0 ? "flushStallLow" : "rstStallLow", ex_stall, 32'd0);
            checkOutput(k == 0 ? "flushCtrl" : "rstCtrl", {EX_MEM_RegWrite, EX_MEM_MemtoRegOut,
                        EX_MEM_MemWriteOut, EX_MEM_MemReadOut, EX_MEM_Branch}, 32'd0);
            applyStimulus(5'd6, 32'd3, 32'd4, 32'd0, 1'b0, 5'b10000, 8'd0);
            tick();
            checkOutput(k == 0 ? "flushAddAfter" : "rstAddAfter", EX_MEM_ALUResult, 32'd7);
            checkOutput(k == 0 ? "flushAddWrite" : "rstAddWrite", EX_MEM_RegWrite, 32'd1);
        end

        applyStimulus(5'd9, 32'd100, 32'd7, 32'd0, 1'b0, 5'b10000, 8'd0);
        #1;
        waitStallLow(cycles, bubbleBad);
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        checkOutput("flushBeatsDone", EX_MEM_RegWrite, 32'd0);
        applyNop();
        #1;
        checkOutput("flushDoneStall", ex_stall, 32'd0);
`else
        applyStimulus(5'd9, 32'd100, 32'd7, 32'd0, 1'b0, 5'b00000, 8'd0);
        #1;
        checkOutput("divNopStall", ex_stall, 32'd0);
        tick();
        checkOutput("divNopStallHeld", ex_stall, 32'd0);
`endif

        rst = 1'b1;
        applyNop();
        tick();
        rst = 1'b0;
        modelFlags = 3'b000;

        for (int i = 0; i < 200; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd9) op = 5'd14;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = b % 8;
            imm = $urandom;
            aluSrc = 1'($urandom);
            ctrl = 5'($urandom);
            pc = 8'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            applyStimulus(op, a, b, imm, aluSrc, ctrl, pc);
            ex_flush = flush;
            expRd = ID_EX_Rd;
            expRes = refResult(op, a, b, imm, aluSrc, pc, resDefined);
            isBranchOp = (op >= 5'd16 && op <= 5'd20);
            expTaken = isBranchOp && (op != 5'd18 || (modelFlags & b[2:0]) != 3'b000);
            case (op)
                5'd17:   expTarget = pc + imm[7:0];
                5'd20:   expTarget = b[7:0];
                default: expTarget = a[7:0];
            endcase
            tick();
            ex_flush = 1'b0;
            if (op == 5'd14 && !flush)
                modelFlags = {a > b, a < b, a == b};
            checkOutput("rndFlags", EX_MEM_Flags, modelFlags);
            if (flush) begin
                checkOutput("rndFlushCtrl", {EX_MEM_RegWrite, EX_MEM_MemtoRegOut, EX_MEM_MemWriteOut,
                            EX_MEM_MemReadOut, EX_MEM_Branch}, 32'd0);
            end else begin
                checkOutput("rndCtrl", {EX_MEM_RegWrite, EX_MEM_MemtoRegOut, EX_MEM_MemWriteOut,
                            EX_MEM_MemReadOut}, ctrl[4:1]);
                checkOutput("rndBranch", EX_MEM_Branch, ctrl[0] & expTaken);
                checkOutput("rndWriteData", EX_MEM_WriteData, b);
                checkOutput("rndWriteReg", EX_MEM_WriteReg, expRd);
                if (resDefined) checkOutput("rndResult", EX_MEM_ALUResult, expRes);
                if (isBranchOp) checkOutput("rndTarget", EX_MEM_BranchTarget, expTarget);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
